// File: rtl/add_accum.sv
// Multi-operand accumulator: sums bursts of N operands with sticky carry/overflow flags.
// Define ADD_ACCUM_SAT_EN to saturate the accumulator to all ones on unsigned carry.
module add_accum #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_co,
  output logic         out_v
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] acc, acc_nxt;
  logic [7:0]   cnt;
  logic         co_q, v_q;
  logic [W:0]   raw;
  logic         add_c, add_v;
  logic         accept, take, last;

  // Flags always come from the raw add, even when the stored sum saturates.
  always_comb begin
    raw   = {1'b0, acc} + {1'b0, in_data};
    add_c = raw[W];
    add_v = (acc[W-1] == in_data[W-1]) && (raw[W-1] != acc[W-1]);
`ifdef ADD_ACCUM_SAT_EN
    acc_nxt = add_c ? '1 : raw[W-1:0];
`else
    acc_nxt = raw[W-1:0];
`endif
  end

  assign last = (cnt == 8'(N - 1));

  // in_ready is held low during reset so no operand is acknowledged then lost.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    case (state)
      ACC: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept && last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        take      = out_ready;
        if (take) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      co_q  <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        acc  <= '0;
        cnt  <= '0;
        co_q <= 1'b0;
        v_q  <= 1'b0;
      end else if (accept) begin
        acc  <= acc_nxt;
        cnt  <= cnt + 8'd1;
        co_q <= co_q | add_c;
        v_q  <= v_q | add_v;
      end
    end
  end

  assign out_sum = acc;
  assign out_co  = co_q;
  assign out_v   = v_q;

endmodule

// File: doc/add_accum.md
# add_accum

Multi-operand accumulator stage placed directly downstream of the full adders. It accepts a stream of W-bit operands over a valid/ready handshake and sums each group of N operands using the add_full_4 carry/overflow semantics. It then presents the W-bit sum plus sticky unsigned-carry and signed-overflow flags on an output handshake. Results feed the status/observation logic that follows the adder datapath.

## Interface
- `W`, default 4: operand and sum width in bits; ≥ 2.
- `N`, default 4: operands per burst; 1 ≤ N ≤ 255.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: block can accept an operand this cycle.
- `in_data`, input, W: operand; unsigned for `out_co`, two's complement for `out_v`.
- `out_valid`, output, 1: burst result is available.
- `out_ready`, input, 1: consumer takes the result this cycle.
- `out_sum`, output, W: accumulated sum, mod 2^W, or saturated when saturation is compiled in.
- `out_co`, output, 1: sticky flag; some add in the burst produced a carry out of bit W-1.
- `out_v`, output, 1: sticky flag; some add in the burst produced signed overflow.

## Operation
- FSM has two states.
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept: a transfer occurs when `in_valid` and `in_ready` are both 1 on a clock edge.
  - The accumulator `acc` is updated to `acc + in_data`.
  - The 8-bit operand counter `cnt` increments.
- Per-add flags, with raw sum `s = acc + in_data` at W+1 bits:
  - `c = s[W]`.
  - `v = (acc[W-1] == in_data[W-1]) && (s[W-1] != acc[W-1])`.
  - `out_co` is the OR of all `c` in the burst. `out_v` is the OR of all `v`.
- Transition ACC→HOLD on the accept where `cnt == N-1`. That operand is included in the sum.
- Transition HOLD→ACC on the edge where `out_ready` is 1.
  - `acc`, `cnt`, `out_co` and `out_v` clear to 0 on that same edge.
- In HOLD, `in_valid` is ignored. `out_sum`, `out_co` and `out_v` stay stable until taken.
- `out_sum` = `acc`. The flags are registered; no output is a combinational function of the current inputs.
- Reset: `rst`=1 forces state ACC and `acc`=`cnt`=`out_co`=`out_v`=0.
  - `out_valid`=0 and `out_sum`=0 on the cycle after the reset edge.
  - `in_ready` is forced to 0 while `rst` is high. It is 1 on the first cycle after `rst` is released.
- Reset mid-burst discards partial state. The next accept is operand 1 of a new burst.
- `rst` and a handshake on the same edge: reset wins, and the transfer is lost.
- N=1: every accepted operand produces a result; `out_sum` equals the operand, and both flags are 0.

## Timing
- Result latency: `out_valid` rises on the cycle after the edge that accepts the Nth operand.
- Minimum burst period is N+1 cycles: N accepts plus one HOLD cycle with `out_ready`=1.
- `in_ready` goes high in the cycle after the output handshake edge. No operand is accepted in the same cycle as a result is taken.
- Gaps in `in_valid` stretch the burst but do not change the result.
- Backpressure on `out_ready` holds HOLD indefinitely; no data is lost.

## Configuration
- `ADD_ACCUM_SAT_EN` defined: unsigned saturation.
  - When `c`=1, `acc` is loaded with all ones (2^W-1) instead of `s[W-1:0]`.
  - `out_co` and `out_v` are still computed from the raw, unsaturated add.
- `ADD_ACCUM_SAT_EN` undefined: `acc` wraps modulo 2^W. This is the default build.

## Test plan
All scenarios use W=4, N=4.
1. Operands 1,2,3,4 back-to-back, `out_ready`=1 → `out_valid` on cycle 5; `out_sum`=4'hA, `out_co`=0, `out_v`=1 (6+4 overflows).
2. Operands F,F,0,0 → wrap build: `out_sum`=4'hE, `out_co`=1, `out_v`=0. With `ADD_ACCUM_SAT_EN`: `out_sum`=4'hF, `out_co`=1, `out_v`=0.
3. Operands 1,1,1,1 with `in_valid` asserted every other cycle → `out_sum`=4'h4. `out_valid` appears one cycle after the 4th accept.
4. Burst 5,5,5,5 with `out_ready` held 0 for 5 cycles while `in_valid`=1 with data 7 → `out_valid` stays 1, `in_ready` stays 0, `out_sum`=4'h4 is stable, and the 7s are not consumed.
5. Assert `rst` after 2 accepted operands (3,3), then send 1,1,1,1 → `out_sum`=4'h4, `out_co`=0, `out_v`=0. All outputs are 0 the cycle after the reset edge.
6. Two bursts, 2,2,2,2 then 8,8,8,8, with `in_valid` and `out_ready` held at 1:
   - First result: `out_sum`=4'h8, `out_co`=0, `out_v`=1.
   - Second result: `out_sum`=4'h0, `out_co`=1, `out_v`=1.
   - Exactly one idle HOLD cycle separates the bursts, and the flags are cleared between them.
